wb_led_matrix_ctrl: RTL and testbench

Parametrised Wishbone slave that owns a multiplexed LED matrix: a register file for control, status, scan divider and per-row pixel data, plus a row-scan engine driving one-hot row strobes and column data. It replaces the fixed single-register LED slave on the SoC Wishbone bus. It adds configurable wait states, an error response for unmapped addresses, byte-lane writes, a frame-done interrupt and an optional PWM brightness stage.

---
 rtl/wb_led_pkg.sv | 29 ++
 rtl/wb_led_matrix_ctrl_scan_engine.sv | 72 +++++++
 rtl/wb_led_matrix_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_wb_led_matrix_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_led_pkg.sv
// Shared constants for the Wishbone LED matrix controller: register word offsets,
// CTRL/STATUS bit positions and the bus FSM encoding.
package wb_led_pkg;

  localparam int MAX_ROWS = 16;

  // Word offsets, i.e. adr_i[7:2]
  localparam logic [5:0] ADR_CTRL   = 6'h00;
  localparam logic [5:0] ADR_STATUS = 6'h01;
  localparam logic [5:0] ADR_DIV    = 6'h02;
  localparam logic [5:0] ADR_ROW0   = 6'h04;

  localparam int CTRL_SCAN_EN    = 0;
  localparam int CTRL_BLANK      = 1;
  localparam int CTRL_IRQ_EN     = 2;
  localparam int CTRL_DUTY_LSB   = 8;
  localparam int STAT_FRAME_DONE = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } bus_state_t;

  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/wb_led_matrix_ctrl_scan_engine.sv
// Row-scan engine: clock divider, row counter, frame wrap pulse and registered row/column drive.
// With LED_PWM_EN defined, a free-running 8-bit counter gates the columns by duty.
module led_scan_engine
  import wb_led_pkg::*;
#(
  parameter int NUM_ROWS = 8,
  parameter int COL_W    = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                scan_en,
  input  logic                blank,
`ifdef LED_PWM_EN
  input  logic [7:0]          duty,
`endif
  input  logic [15:0]         div,
  input  logic [COL_W-1:0]    row_data,
  output logic [3:0]          row_idx,
  output logic                frame_wrap,
  output logic [NUM_ROWS-1:0] row_o,
  output logic [COL_W-1:0]    col_o
);

  localparam logic [NUM_ROWS-1:0] ROW_ONE = NUM_ROWS'(1);

  logic [15:0] div_cnt;
  logic [15:0] div_last;
  logic        tc;
  logic        show;
  logic        pwm_on;

  // DIV of 0 behaves like 1 so the scan never stalls
  assign div_last   = (div == 16'd0) ? 16'd0 : div - 16'd1;
  assign tc         = scan_en && (div_cnt >= div_last);
  assign frame_wrap = tc && (row_idx == 4'(NUM_ROWS - 1));
  assign show       = scan_en && !blank;

`ifdef LED_PWM_EN
  logic [7:0] pwm_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pwm_cnt <= 8'd0;
    else         pwm_cnt <= pwm_cnt + 8'd1;
  end

  assign pwm_on = (pwm_cnt < duty);
`else
  assign pwm_on = 1'b1;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_cnt <= 16'd0;
      row_idx <= 4'd0;
      row_o   <= '0;
      col_o   <= '0;
    end else begin
      if (!scan_en) begin
        div_cnt <= 16'd0;
        row_idx <= 4'd0;
      end else if (tc) begin
        div_cnt <= 16'd0;
        row_idx <= frame_wrap ? 4'd0 : row_idx + 4'd1;
      end else begin
        div_cnt <= div_cnt + 16'd1;
      end
      row_o <= show ? (ROW_ONE << row_idx) : '0;
      col_o <= (show && pwm_on) ? row_data : '0;
    end
  end

endmodule

// File: rtl/wb_led_matrix_ctrl.sv
// Wishbone slave owning a multiplexed LED matrix; bus FSM and register file live here.
// Optional PWM brightness stage enabled by defining LED_PWM_EN.
//   state | meaning
//   IDLE  | waiting for stb_i & cyc_i, request latched on acceptance
//   WAIT  | counting WAIT_STATES cycles, cyc_i low aborts
//   RESP  | one-cycle ack_o/err_o with dat_o, write committed on entry
module wb_led_matrix_ctrl
  import wb_led_pkg::*;
#(
  parameter int          NUM_ROWS    = 8,
  parameter int          COL_W       = 32,
  parameter int          WAIT_STATES = 1,
  parameter logic [15:0] SCAN_DIV    = 16'd1000
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [31:0]         adr_i,
  input  logic [31:0]         dat_i,
  output logic [31:0]         dat_o,
  input  logic                we_i,
  input  logic                stb_i,
  input  logic                cyc_i,
  input  logic [3:0]          sel_i,
  output logic                ack_o,
  output logic                err_o,
  output logic [NUM_ROWS-1:0] row_o,
  output logic [COL_W-1:0]    col_o,
  output logic                irq_o
);

  localparam logic [1:0] WAIT_INIT = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;
`ifdef LED_PWM_EN
  localparam logic [15:0] CTRL_MASK = 16'hFF07;
`else
  localparam logic [15:0] CTRL_MASK = 16'h0007;
`endif

  bus_state_t       state;
  logic [1:0]       wait_cnt;
  logic [5:0]       req_adr;
  logic             req_we;
  logic [3:0]       req_sel;
  logic [31:0]      req_dat;

  logic [15:0]      ctrl_q;
  logic [15:0]      div_q;
  logic             frame_done;
  logic [COL_W-1:0] row_q [MAX_ROWS];

  logic [5:0]       cur_adr;
  logic             cur_we;
  logic [31:0]      cur_dat;
  logic [31:0]      wmask;
  logic [5:0]       row_sel;
  logic             row_hit;
  logic             hit;
  logic [31:0]      rdata;
  logic             go_resp;
  logic             wr;
  logic [COL_W-1:0] row_new;

  logic [3:0]       row_idx;
  logic             frame_wrap;
  logic             unused_adr;

  assign unused_adr = ^{adr_i[31:8], adr_i[1:0]};

  // With no wait states the response is decided from the live bus inputs
  assign cur_adr = (state == IDLE) ? adr_i[7:2] : req_adr;
  assign cur_we  = (state == IDLE) ? we_i       : req_we;
  assign cur_dat = (state == IDLE) ? dat_i      : req_dat;
  assign wmask   = lane_mask((state == IDLE) ? sel_i : req_sel);
  assign row_sel = cur_adr - ADR_ROW0;
  assign row_hit = (cur_adr >= ADR_ROW0) && (row_sel < 6'(NUM_ROWS));
  assign row_new = (row_q[row_sel[3:0]] & ~wmask[COL_W-1:0]) | (cur_dat[COL_W-1:0] & wmask[COL_W-1:0]);

  assign go_resp = ((state == IDLE) && stb_i && cyc_i && (WAIT_STATES == 0)) ||
                   ((state == WAIT) && cyc_i && (wait_cnt == 2'd0));
  assign wr      = go_resp && hit && cur_we;

  always_comb begin
    hit   = 1'b1;
    rdata = '0;
    if (cur_adr == ADR_CTRL) begin
      rdata[15:0] = ctrl_q;
    end else if (cur_adr == ADR_STATUS) begin
      rdata[3:0]             = row_idx;
      rdata[STAT_FRAME_DONE] = frame_done;
    end else if (cur_adr == ADR_DIV) begin
      rdata[15:0] = div_q;
    end else if (row_hit) begin
      rdata = 32'(row_q[row_sel[3:0]]);
    end else begin
      hit = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      wait_cnt <= 2'd0;
      req_adr  <= '0;
      req_we   <= 1'b0;
      req_sel  <= '0;
      req_dat  <= '0;
      ack_o    <= 1'b0;
      err_o    <= 1'b0;
      dat_o    <= '0;
    end else begin
      ack_o <= 1'b0;
      err_o <= 1'b0;
      if (go_resp) begin
        state <= RESP;
        ack_o <= hit;
        err_o <= !hit;
        dat_o <= (hit && !cur_we) ? rdata : '0;
      end else begin
        case (state)
          IDLE: begin
            if (stb_i && cyc_i) begin
              state    <= WAIT;
              wait_cnt <= WAIT_INIT;
              req_adr  <= adr_i[7:2];
              req_we   <= we_i;
              req_sel  <= sel_i;
              req_dat  <= dat_i;
            end
          end
          WAIT: begin
            if (!cyc_i) state    <= IDLE;
            else        wait_cnt <= wait_cnt - 2'd1;
          end
          RESP: begin
            state <= IDLE;
            dat_o <= '0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_q     <= '0;
      div_q      <= SCAN_DIV;
      frame_done <= 1'b0;
      irq_o      <= 1'b0;
      for (int i = 0; i < MAX_ROWS; i++) row_q[i] <= '0;
    end else begin
      if (wr && (cur_adr == ADR_CTRL))
        ctrl_q <= ((ctrl_q & ~wmask[15:0]) | (cur_dat[15:0] & wmask[15:0])) & CTRL_MASK;
      if (wr && (cur_adr == ADR_DIV))
        div_q <= (div_q & ~wmask[15:0]) | (cur_dat[15:0] & wmask[15:0]);
      // A wrap in the same cycle as a clear keeps the flag set
      if (frame_wrap)
        frame_done <= 1'b1;
      else if (wr && (cur_adr == ADR_STATUS) && cur_dat[STAT_FRAME_DONE] && wmask[STAT_FRAME_DONE])
        frame_done <= 1'b0;
      for (int i = 0; i < NUM_ROWS; i++)
        if (wr && row_hit && (row_sel[3:0] == 4'(i))) row_q[i] <= row_new;
      irq_o <= frame_done && ctrl_q[CTRL_IRQ_EN];
    end
  end

  led_scan_engine #(
    .NUM_ROWS (NUM_ROWS),
    .COL_W    (COL_W)
  ) u_scan (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .scan_en    (ctrl_q[CTRL_SCAN_EN]),
    .blank      (ctrl_q[CTRL_BLANK]),
`ifdef LED_PWM_EN
    .duty       (ctrl_q[CTRL_DUTY_LSB +: 8]),
`endif
    .div        (div_q),
    .row_data   (row_q[row_idx]),
    .row_idx    (row_idx),
    .frame_wrap (frame_wrap),
    .row_o      (row_o),
    .col_o      (col_o)
  );

endmodule

// File: tb/tb_wb_led_matrix_ctrl.sv
// Directed bench for wb_led_matrix_ctrl with NUM_ROWS=4, WAIT_STATES=1; expectations adapt to LED_PWM_EN.
module tb_wb_led_matrix_ctrl;

  localparam int NR = 4;
  localparam int CW = 32;
  localparam int WS = 1;
`ifdef LED_PWM_EN
  localparam bit PWM = 1'b1;
`else
  localparam bit PWM = 1'b0;
`endif

  logic          clk_i  = 1'b0;
  logic          rst_ni = 1'b0;
  logic [31:0]   adr_i  = '0;
  logic [31:0]   dat_i  = '0;
  logic          we_i   = 1'b0;
  logic          stb_i  = 1'b0;
  logic          cyc_i  = 1'b0;
  logic [3:0]    sel_i  = '0;
  logic [31:0]   dat_o;
  logic          ack_o, err_o, irq_o;
  logic [NR-1:0] row_o;
  logic [CW-1:0] col_o;

  int errors = 0;
  int checks = 0;

  wb_led_matrix_ctrl #(
    .NUM_ROWS(NR), .COL_W(CW), .WAIT_STATES(WS), .SCAN_DIV(16'd1000)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o),
    .we_i(we_i), .stb_i(stb_i), .cyc_i(cyc_i), .sel_i(sel_i), .ack_o(ack_o),
    .err_o(err_o), .row_o(row_o), .col_o(col_o), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  // Called 1 time unit after a rising edge; returns 1 time unit after the turnaround edge.
  task automatic bus_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, output logic [31:0] rd, output logic got_ack,
                          output logic got_err, output int lat, output logic linger);
    adr_i = adr; dat_i = dat; we_i = we; sel_i = sel; stb_i = 1'b1; cyc_i = 1'b1;
    lat = -1; got_ack = 1'b0; got_err = 1'b0; rd = '0;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk_i); #1;
      if (ack_o || err_o) begin
        lat = n; got_ack = ack_o; got_err = err_o; rd = dat_o;
        break;
      end
    end
    stb_i = 1'b0; cyc_i = 1'b0; we_i = 1'b0;
    @(posedge clk_i); #1;
    linger = ack_o | err_o;
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] dat);
    logic [31:0] r; logic a, e, l; int n;
    bus_xfer(1'b1, adr, dat, 4'hF, r, a, e, n, l);
    checks++; if (!(a && !e && n == WS + 1)) begin errors++; $display("FAIL wr_ack adr=%h: ack=%b err=%b lat=%0d, want 1/0/%0d", adr, a, e, n, WS + 1); end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk_i);
    #1;
    checks++; if ({ack_o, err_o, irq_o} !== 3'b000) begin errors++; $display("FAIL rst_flags: got %b want 000", {ack_o, err_o, irq_o}); end
    checks++; if (dat_o !== 32'h0) begin errors++; $display("FAIL rst_dat: got %h want 0", dat_o); end
    checks++; if (row_o !== 4'h0) begin errors++; $display("FAIL rst_row: got %b want 0000", row_o); end
    checks++; if (col_o !== 32'h0) begin errors++; $display("FAIL rst_col: got %h want 0", col_o); end
    rst_ni = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
  endtask

  task automatic test_reads();
    logic [31:0] exp_val [3];
    logic [31:0] adrs [3];
    logic [31:0] r; logic a, e, l; int n;
    adrs[0] = 32'h00; adrs[1] = 32'h08; adrs[2] = 32'h10;
    exp_val[0] = 32'h0; exp_val[1] = 32'd1000; exp_val[2] = 32'h0;
    for (int i = 0; i < 3; i++) begin
      bus_xfer(1'b0, adrs[i], 32'h0, 4'hF, r, a, e, n, l);
      checks++; if (r !== exp_val[i]) begin errors++; $display("FAIL read_val adr=%h: got %h want %h", adrs[i], r, exp_val[i]); end
      checks++; if ({a, e} !== 2'b10) begin errors++; $display("FAIL read_ack adr=%h: ack/err=%b want 10", adrs[i], {a, e}); end
      checks++; if (n != WS + 1) begin errors++; $display("FAIL read_lat adr=%h: got %0d want %0d", adrs[i], n, WS + 1); end
      checks++; if (l !== 1'b0) begin errors++; $display("FAIL ack_len adr=%h: still high after one cycle", adrs[i]); end
    end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] r; logic a, e, l; int n;
    bus_xfer(1'b1, 32'h18, 32'hAABBCCDD, 4'b0101, r, a, e, n, l);
    bus_xfer(1'b0, 32'h18, 32'h0, 4'hF, r, a, e, n, l);
    checks++; if (r !== 32'h00BB00DD) begin errors++; $display("FAIL row2_lanes: got %h want 00bb00dd", r); end
    wr(32'h00, 32'hFFFFFFFA);
    bus_xfer(1'b0, 32'h00, 32'h0, 4'hF, r, a, e, n, l);
    checks++; if (r !== (PWM ? 32'h0000FF02 : 32'h00000002)) begin errors++; $display("FAIL ctrl_mask: got %h want %h", r, PWM ? 32'h0000FF02 : 32'h00000002); end
    wr(32'h00, 32'h0);
    wr(32'h04, 32'hFFFFFFFF);
    bus_xfer(1'b0, 32'h04, 32'h0, 4'hF, r, a, e, n, l);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL status_ro: got %h want 0", r); end
    bus_xfer(1'b1, 32'h08, 32'hFFFF0007, 4'b0001, r, a, e, n, l);
    bus_xfer(1'b0, 32'h08, 32'h0, 4'hF, r, a, e, n, l);
    checks++; if (r !== 32'h00000307) begin errors++; $display("FAIL div_lane: got %h want 00000307", r); end
  endtask

  task automatic test_err();
    logic [31:0] adrs [4];
    logic        wes  [4];
    logic [31:0] r; logic a, e, l; int n;
    adrs[0] = 32'h0C; adrs[1] = 32'h20; adrs[2] = 32'h0C; adrs[3] = 32'h20;
    wes[0] = 1'b0; wes[1] = 1'b0; wes[2] = 1'b1; wes[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus_xfer(wes[i], adrs[i], 32'hFFFFFFFF, 4'hF, r, a, e, n, l);
      checks++; if ({a, e, l} !== 3'b010 || n != WS + 1) begin errors++; $display("FAIL err_resp adr=%h we=%b: ack/err/linger=%b lat=%0d want 010 lat %0d", adrs[i], wes[i], {a, e, l}, n, WS + 1); end
    end
    bus_xfer(1'b0, 32'h08, 32'h0, 4'hF, r, a, e, n, l);
    checks++; if (r !== 32'h00000307) begin errors++; $display("FAIL err_div_kept: got %h want 00000307", r); end
    bus_xfer(1'b0, 32'h1C, 32'h0, 4'hF, r, a, e, n, l);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL err_row3_kept: got %h want 0", r); end
  endtask

  task automatic test_back_to_back();
    int n1, n2;
    logic [31:0] r1, r2;
    n1 = -1; n2 = -1; r1 = '0; r2 = '0;
    adr_i = 32'h08; we_i = 1'b0; sel_i = 4'hF; stb_i = 1'b1; cyc_i = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk_i); #1;
      if (ack_o) begin n1 = n; r1 = dat_o; break; end
    end
    adr_i = 32'h18;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk_i); #1;
      if (ack_o) begin n2 = n; r2 = dat_o; break; end
    end
    stb_i = 1'b0; cyc_i = 1'b0;
    @(posedge clk_i); #1;
    checks++; if (n1 != WS + 1 || r1 !== 32'h00000307) begin errors++; $display("FAIL b2b_first: lat %0d data %h want %0d 00000307", n1, r1, WS + 1); end
    checks++; if (n2 != WS + 2 || r2 !== 32'h00BB00DD) begin errors++; $display("FAIL b2b_second: spacing %0d data %h want %0d 00bb00dd", n2, r2, WS + 2); end
  endtask

  task automatic test_scan();
    logic [3:0]  exp_row;
    logic [31:0] exp_col;
    logic        exp_irq;
    logic [31:0] r; logic a, e, l; int n;
    wr(32'h08, 32'd2);
    wr(32'h00, 32'h5);
    for (int k = 0; k < 22; k++) begin
      if (k > 0) begin @(posedge clk_i); #1; end
      exp_row = 4'b0001 << ((k / 2) % 4);
      exp_col = (((k / 2) % 4) == 2 && !PWM) ? 32'h00BB00DD : 32'h0;
      exp_irq = (k >= 8);
      checks++; if (row_o !== exp_row) begin errors++; $display("FAIL scan_row k=%0d: got %b want %b", k, row_o, exp_row); end
      checks++; if (col_o !== exp_col) begin errors++; $display("FAIL scan_col k=%0d: got %h want %h", k, col_o, exp_col); end
      checks++; if (irq_o !== exp_irq) begin errors++; $display("FAIL scan_irq k=%0d: got %b want %b", k, irq_o, exp_irq); end
    end
    // This clear commits on the same edge as the next wrap
    wr(32'h04, 32'h100);
    bus_xfer(1'b0, 32'h04, 32'h0, 4'hF, r, a, e, n, l);
    checks++; if (r !== 32'h00000101) begin errors++; $display("FAIL w1c_vs_wrap: got %h want 00000101", r); end
    wr(32'h00, 32'h4);
    checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL irq_held: got %b want 1", irq_o); end
    wr(32'h04, 32'h100);
    checks++; if ({irq_o, row_o} !== 5'b0) begin errors++; $display("FAIL w1c_clear_out: irq/row=%b want 00000", {irq_o, row_o}); end
    bus_xfer(1'b0, 32'h04, 32'h0, 4'hF, r, a, e, n, l);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL w1c_clear: got %h want 0", r); end
    wr(32'h00, 32'h0);
  endtask

  task automatic test_blank();
    wr(32'h00, 32'h3);
    repeat (5) @(posedge clk_i);
    #1;
    checks++; if (row_o !== 4'h0 || col_o !== 32'h0) begin errors++; $display("FAIL blank: row %b col %h want 0", row_o, col_o); end
    wr(32'h00, 32'h0);
  endtask

  task automatic test_abort();
    logic seen;
    logic [31:0] r; logic a, e, l; int n;
    seen = 1'b0;
    adr_i = 32'h08; dat_i = 32'h55; we_i = 1'b1; sel_i = 4'hF; stb_i = 1'b1; cyc_i = 1'b1;
    @(posedge clk_i); #1;
    stb_i = 1'b0; cyc_i = 1'b0; we_i = 1'b0;
    repeat (4) begin
      @(posedge clk_i); #1;
      seen = seen | ack_o | err_o;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_resp: got a response, want none"); end
    bus_xfer(1'b0, 32'h08, 32'h0, 4'hF, r, a, e, n, l);
    checks++; if (r !== 32'd2) begin errors++; $display("FAIL abort_div: got %h want 2", r); end
  endtask

  task automatic test_pwm();
    int ones, other;
    logic [31:0] r; logic a, e, l; int n;
    for (int i = 0; i < NR; i++) wr(32'h10 + 32'(4 * i), 32'hFFFFFFFF);
    wr(32'h00, 32'h4001);
    bus_xfer(1'b0, 32'h00, 32'h0, 4'hF, r, a, e, n, l);
    checks++; if (r !== (PWM ? 32'h4001 : 32'h0001)) begin errors++; $display("FAIL duty_read: got %h want %h", r, PWM ? 32'h4001 : 32'h0001); end
    ones = 0; other = 0;
    for (int c = 0; c < 256; c++) begin
      @(posedge clk_i); #1;
      if (col_o === 32'hFFFFFFFF) ones++;
      else if (col_o !== 32'h0) other++;
    end
    checks++; if (ones != (PWM ? 64 : 256) || other != 0) begin errors++; $display("FAIL pwm_40: on=%0d odd=%0d want on=%0d odd=0", ones, other, PWM ? 64 : 256); end
    wr(32'h00, 32'h0001);
    ones = 0; other = 0;
    for (int c = 0; c < 256; c++) begin
      @(posedge clk_i); #1;
      if (col_o === 32'hFFFFFFFF) ones++;
      else if (col_o !== 32'h0) other++;
    end
    checks++; if (ones != (PWM ? 0 : 256) || other != 0) begin errors++; $display("FAIL pwm_00: on=%0d odd=%0d want on=%0d odd=0", ones, other, PWM ? 0 : 256); end
    wr(32'h00, 32'h0);
  endtask

  task automatic test_reset_mid();
    logic seen;
    logic [31:0] r; logic a, e, l; int n;
    wr(32'h00, 32'h1);
    checks++; if (row_o !== 4'b0001) begin errors++; $display("FAIL pre_rst_row: got %b want 0001", row_o); end
    adr_i = 32'h08; dat_i = 32'h1234; we_i = 1'b1; sel_i = 4'hF; stb_i = 1'b1; cyc_i = 1'b1;
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    #1;
    checks++; if ({ack_o, err_o, irq_o, row_o} !== 7'b0 || dat_o !== 32'h0 || col_o !== 32'h0) begin errors++; $display("FAIL mid_rst_out: ack/err/irq/row=%b dat=%h col=%h want all 0", {ack_o, err_o, irq_o, row_o}, dat_o, col_o); end
    seen = 1'b0;
    repeat (2) begin
      @(posedge clk_i); #1;
      seen = seen | ack_o | err_o;
    end
    stb_i = 1'b0; cyc_i = 1'b0; we_i = 1'b0;
    rst_ni = 1'b1;
    repeat (3) begin
      @(posedge clk_i); #1;
      seen = seen | ack_o | err_o;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_rst_ack: response seen after reset"); end
    bus_xfer(1'b0, 32'h08, 32'h0, 4'hF, r, a, e, n, l);
    checks++; if (r !== 32'd1000) begin errors++; $display("FAIL mid_rst_div: got %h want 3e8", r); end
    bus_xfer(1'b0, 32'h00, 32'h0, 4'hF, r, a, e, n, l);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL mid_rst_ctrl: got %h want 0", r); end
    bus_xfer(1'b0, 32'h10, 32'h0, 4'hF, r, a, e, n, l);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL mid_rst_row0: got %h want 0", r); end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_reads();
    test_byte_lanes();
    test_err();
    test_back_to_back();
    test_scan();
    test_blank();
    test_abort();
    test_pwm();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
